sat_mac: RTL
============

SAT_MAC -- requirements
Module: sat_mac

Interface
REQ-001 Parameter N, default 25: operand, accumulator and output width in bits, signed two's complement.
REQ-002 Parameter F, default 8: fractional bits of the fixed-point format; range 1..N-2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  A and B are valid this cycle and are accepted.
REQ-006 clr  input  1  clears the accumulator and the overflow flag.
REQ-007 A  input  N  signed multiplicand.
REQ-008 B  input  N  signed multiplier.
REQ-009 acc_out  output  N  signed saturated accumulator value, registered.
REQ-010 out_valid  output  1  acc_out was updated by a new sample this cycle; one-cycle pulse.
REQ-011 ovf  output  1  sticky flag: saturation has occurred since the last clr or reset.

Function
REQ-012 The limits SHALL be symmetric: MAX = 2^(N-1)-1, MIN = -(2^(N-1)-1); the value -2^(N-1) SHALL never appear on acc_out.
REQ-013 Stage 1 SHALL register the full 2N-bit signed product A*B and a valid bit when in_valid=1.
REQ-014 Stage 2 SHALL arithmetically shift the product right by F bits, then clamp the result to [MIN, MAX]; clamping SHALL set ovf.
REQ-015 Stage 2 SHALL add the clamped term to the accumulator at N+1 bits and clamp the sum to [MIN, MAX]; clamping SHALL set ovf.
REQ-016 Latency: a sample accepted in cycle t SHALL produce acc_out and out_valid=1 in cycle t+2.
REQ-017 Throughput SHALL be one sample per cycle with no stall; there is no backpressure.
REQ-018 acc_out SHALL hold its value in cycles with out_valid=0.
REQ-019 When clr=1 in cycle t, the accumulator SHALL be 0 and ovf SHALL be 0 in t+1, and any sample in stage 1 or stage 2 SHALL be discarded, with no out_valid for it.
REQ-020 A sample presented with in_valid=1 in the same cycle as clr=1 SHALL be accepted and SHALL be the first term after the clear (acc_out equals its term at t+2).
REQ-021 ovf SHALL stay 1 until clr or reset; a saturation event in the same cycle as clr SHALL be discarded together with its sample.
REQ-022 Once saturated, the accumulator SHALL leave the limit only by adding terms of opposite sign; it SHALL never wrap.

Reset
REQ-023 When reset=1 the block SHALL drive, on the next edge, acc_out=0, out_valid=0 and ovf=0, and SHALL clear both pipeline valid bits.
REQ-024 reset SHALL take priority over clr and in_valid; a sample presented during reset SHALL be discarded.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight samples, with no out_valid after the reset edge until a new sample has been accepted.

Configuration
REQ-026 With macro SAT_MAC_ROUND_EN defined, stage 2 SHALL add 2^(F-1) to the product before the right shift (round half up).
REQ-027 Without SAT_MAC_ROUND_EN, stage 2 SHALL truncate by plain arithmetic shift (toward minus infinity); latency is identical in both builds.

Verification
REQ-028 N=25, F=8, reset, then A=256, B=256 for one cycle -> out_valid at t+2, acc_out=256, ovf=0.
REQ-029 A=1, B=128 for one cycle -> acc_out=0 without SAT_MAC_ROUND_EN, acc_out=1 with it.
REQ-030 A=16777215, B=16777215 for two consecutive cycles -> acc_out=16777215, ovf=1; then A=-256, B=256 for one cycle -> acc_out=16776959, ovf remains 1.
REQ-031 A=-16777215, B=16777215 for three consecutive cycles -> acc_out=-16777215, never -16777216, and ovf=1.
REQ-032 Stream of A=256, B=256 for 4 cycles, with clr=1 in cycle 2 -> the cycle-1 sample is discarded; acc_out reads 256, 512, 768 on the out_valid pulses that follow the clear; ovf=0.
REQ-033 reset asserted with two samples in flight -> acc_out=0, out_valid=0 and ovf=0 after the edge, and no out_valid pulse follows.

Source files
------------

// File: rtl/sat_mac_if.sv
// sat_mac_if: sample/result bus of the saturating fixed-point MAC.
// The master drives the operands and controls. The slave (sat_mac) returns the accumulator and flags.
interface sat_mac_if #(
    parameter int N = 25
);
    logic                in_valid;
    logic                clr;
    logic signed [N-1:0] A;
    logic signed [N-1:0] B;
    logic signed [N-1:0] acc_out;
    logic                out_valid;
    logic                ovf;

    modport master (
        output in_valid, clr, A, B,
        input  acc_out, out_valid, ovf
    );

    modport slave (
        input  in_valid, clr, A, B,
        output acc_out, out_valid, ovf
    );
endinterface

// File: rtl/sat_mac.sv
// sat_mac: two-stage signed fixed-point multiply-accumulate with symmetric saturation.
// Stage 1 registers the full product. Stage 2 scales it, clamps it, and accumulates
// it with a second clamp. A sticky ovf flag records any clamp.
// Optional build macro SAT_MAC_ROUND_EN adds round-half-up before the scaling shift.
// When the macro is undefined, the scaling truncates toward minus infinity.
module sat_mac #(
    parameter int N = 25,
    parameter int F = 8
) (
    input  logic       clk,
    input  logic       reset,
    sat_mac_if.slave   bus
);
    localparam int PW = 2 * N;
    localparam int RW = 2 * N + 1;

    localparam logic signed [N-1:0]  MAX_N = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]  MIN_N = {1'b1, {(N-2){1'b0}}, 1'b1};
    localparam logic signed [RW-1:0] MAX_R = {{(RW-N){1'b0}}, MAX_N};
    localparam logic signed [RW-1:0] MIN_R = {{(RW-N){1'b1}}, MIN_N};
    localparam logic signed [N:0]    MAX_S = {1'b0, MAX_N};
    localparam logic signed [N:0]    MIN_S = {1'b1, MIN_N};
`ifdef SAT_MAC_ROUND_EN
    localparam logic signed [RW-1:0] HALF  = {{(RW-1){1'b0}}, 1'b1} << (F - 1);
`endif

    logic signed [PW-1:0] prod_q, prod_d;
    logic                 v1_q, v1_d;
    logic signed [N-1:0]  acc_q, acc_d;
    logic                 vld_q, vld_d;
    logic                 ovf_q, ovf_d;

    logic signed [PW-1:0] a_ext, b_ext;
    logic signed [RW-1:0] prod_ext, scaled;
    logic signed [N-1:0]  term;
    logic                 term_sat;
    logic signed [N:0]    sum;
    logic signed [N-1:0]  sum_cl;
    logic                 sum_sat;

    // Stage 1: form the full-width product of the accepted sample.
    // A sample presented together with clr is still captured.
    always_comb begin
        a_ext  = {{N{bus.A[N-1]}}, bus.A};
        b_ext  = {{N{bus.B[N-1]}}, bus.B};
        prod_d = bus.in_valid ? a_ext * b_ext : prod_q;
        v1_d   = bus.in_valid;
    end

    // Stage 2: scale, clamp the term, accumulate at N+1 bits, clamp the sum.
    // clr drops whatever stage 1 holds.
    always_comb begin
        prod_ext = {prod_q[PW-1], prod_q};
`ifdef SAT_MAC_ROUND_EN
        scaled   = (prod_ext + HALF) >>> F;
`else
        scaled   = prod_ext >>> F;
`endif
        term_sat = 1'b0;
        if (scaled > MAX_R) begin
            term     = MAX_N;
            term_sat = 1'b1;
        end else if (scaled < MIN_R) begin
            term     = MIN_N;
            term_sat = 1'b1;
        end else begin
            term     = scaled[N-1:0];
        end

        sum     = {acc_q[N-1], acc_q} + {term[N-1], term};
        sum_sat = 1'b0;
        if (sum > MAX_S) begin
            sum_cl  = MAX_N;
            sum_sat = 1'b1;
        end else if (sum < MIN_S) begin
            sum_cl  = MIN_N;
            sum_sat = 1'b1;
        end else begin
            sum_cl  = sum[N-1:0];
        end

        acc_d = acc_q;
        vld_d = 1'b0;
        ovf_d = ovf_q;
        if (bus.clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (v1_q) begin
            acc_d = sum_cl;
            vld_d = 1'b1;
            ovf_d = ovf_q | term_sat | sum_sat;
        end
    end

    // Pipeline and accumulator registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            acc_q  <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            v1_q   <= v1_d;
            acc_q  <= acc_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.acc_out   = acc_q;
    assign bus.out_valid = vld_q;
    assign bus.ovf       = ovf_q;
endmodule
